// File: rtl/master_port_pkg.sv
// Shared serial-bus definitions: mode encoding, FSM states, default widths.
// No logic; imported by the master port, its deserialiser and the slave port.
// Widths here are defaults only; instances may override them.
package master_port_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    ADDR     = 3'd2,
    WDATA    = 3'd3,
    RDATA    = 3'd4,
    DONE     = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/master_port_serial_rx_shift.sv
// LSB-first serial-to-parallel deserialiser with bit counter and done flag.
// Latency: done and the full word are visible the cycle after the last bit is sampled.
// No backpressure: bits arriving once the word is complete are dropped until clr.
module serial_rx_shift
  import master_port_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  in_vld,
  input  logic                  in_bit,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;

  // Place each valid bit at the current position; freeze once the word is full.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr) begin
      data_d = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (in_vld && !done_q) begin
      data_d[cnt_q[IDX_W-1:0]] = in_bit;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
        done_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign data = data_q;
  assign done = done_q;

endmodule

// File: rtl/master_port.sv
// Serial-bus master: takes one parallel read/write, serialises addr/wdata LSB-first, collects read bits.
// Latency: first addr bit one cycle after sready is seen; ddone two cycles after the last bit moves.
// Backpressure: dready low while busy; waits indefinitely for sready, read aborts after TIMEOUT idle cycles.
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  output logic                  dready,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready
);

  localparam int CNT_W  = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int AIDX_W = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam int DIDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;
  logic                  err_q, err_d;
  logic                  mvalid_q, mvalid_d;
  logic                  mwdata_q, mwdata_d;
  logic                  mmode_q, mmode_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  ddone_q, ddone_d;
  logic                  derr_q, derr_d;

  logic                  rx_clr;
  logic                  rx_vld;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;

  // Only bits seen while actually waiting for read data reach the deserialiser.
  assign rx_vld = svalid && (state_q == RDATA);

  serial_rx_shift #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (rx_clr),
    .in_vld (rx_vld),
    .in_bit (srdata),
    .data   (rx_data),
    .done   (rx_done)
  );

  // Next-state and registered-output logic; cnt_q == width means the last bit is on the wire.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    mvalid_d = mvalid_q;
    mwdata_d = mwdata_q;
    mmode_d  = mmode_q;
    drdata_d = drdata_q;
    ddone_d  = 1'b0;
    derr_d   = 1'b0;
    rx_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dvalid) begin
          mode_d  = mode_e'(dmode);
          addr_d  = daddr;
          wdata_d = dwdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (sready) begin
          mvalid_d = 1'b1;
          mmode_d  = mode_q;
          mwdata_d = addr_q[0];
          cnt_d    = CNT_W'(1);
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (cnt_q == CNT_W'(ADDR_WIDTH)) begin
          if (mode_q == MODE_WRITE) begin
            mwdata_d = wdata_q[0];
            cnt_d    = CNT_W'(1);
            state_d  = WDATA;
          end else begin
            mvalid_d = 1'b0;
            mwdata_d = 1'b0;
            mmode_d  = 1'b0;
            cnt_d    = '0;
            tcnt_d   = '0;
            rx_clr   = 1'b1;
            state_d  = RDATA;
          end
        end else begin
          mwdata_d = addr_q[cnt_q[AIDX_W-1:0]];
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      WDATA: begin
        if (cnt_q == CNT_W'(DATA_WIDTH)) begin
          mvalid_d = 1'b0;
          mwdata_d = 1'b0;
          mmode_d  = 1'b0;
          state_d  = DONE;
        end else begin
          mwdata_d = wdata_q[cnt_q[DIDX_W-1:0]];
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      RDATA: begin
        if (rx_done) begin
          drdata_d = rx_data;
          state_d  = DONE;
        end else if (svalid) begin
          tcnt_d = '0;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      DONE: begin
        ddone_d = 1'b1;
        derr_d  = err_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transaction without a completion pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      mode_q   <= MODE_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      mvalid_q <= 1'b0;
      mwdata_q <= 1'b0;
      mmode_q  <= 1'b0;
      drdata_q <= '0;
      ddone_q  <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      mvalid_q <= mvalid_d;
      mwdata_q <= mwdata_d;
      mmode_q  <= mmode_d;
      drdata_q <= drdata_d;
      ddone_q  <= ddone_d;
      derr_q   <= derr_d;
    end
  end

  assign dready = (state_q == IDLE);
  assign mvalid = mvalid_q;
  assign mwdata = mwdata_q;
  assign mmode  = mmode_q;
  assign drdata = drdata_q;
  assign ddone  = ddone_q;
  assign derr   = derr_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: write/read serialisation, sready stall, read timeout, reset mid-transfer.
// Capture cycle 0 is always the WAIT_RDY cycle that sees sready=1 (cycle T).
// Inputs change 1 ns after the rising edge, outputs are sampled there too.
module tb_master_port;
  import master_port_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          dvalid;
  logic          dready;
  logic          dmode;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] drdata;
  logic          ddone;
  logic          derr;
  logic          mwdata;
  logic          mmode;
  logic          mvalid;
  logic          srdata;
  logic          svalid;
  logic          sready;

  always #5 clk = ~clk;

  master_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .dvalid (dvalid),
    .dready (dready),
    .dmode  (dmode),
    .daddr  (daddr),
    .dwdata (dwdata),
    .drdata (drdata),
    .ddone  (ddone),
    .derr   (derr),
    .mwdata (mwdata),
    .mmode  (mmode),
    .mvalid (mvalid),
    .srdata (srdata),
    .svalid (svalid),
    .sready (sready)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic vec_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the last capture window.
  logic [31:0] cap_bits;
  int          cap_nvld, cap_first, cap_last, cap_done_at, cap_ndone, cap_slast;
  logic        cap_err, cap_mmode, cap_rdy;
  logic [7:0]  cap_rd;

  // Slave model controls: enable read response, response word, svalid noise level.
  logic        sl_en;
  logic [7:0]  sl_resp;
  logic        sl_noise;

  // Watch the bus for ncyc cycles; a read slave answers once mvalid drops after a read address.
  // Response: bits 0-3, one idle cycle, bits 4-7, then two surplus bits.
  task automatic capture(input int ncyc);
    logic prev_vld;
    logic was_rd;
    logic sl_on;
    int   slot;
    int   idx;
    prev_vld = 1'b0;
    was_rd   = 1'b0;
    sl_on    = 1'b0;
    slot     = 0;
    cap_bits = '0;
    cap_nvld = 0;
    cap_first = -1;
    cap_last = -1;
    cap_done_at = -1;
    cap_ndone = 0;
    cap_slast = -1;
    cap_err = 1'bx;
    cap_mmode = 1'bx;
    cap_rdy = 1'bx;
    cap_rd = 'x;
    for (int c = 0; c < ncyc; c++) begin
      if (mvalid) begin
        cap_bits = cap_bits | (32'(mwdata) << cap_nvld);
        if (cap_first < 0) cap_first = c;
        cap_last  = c;
        cap_nvld++;
        cap_mmode = mmode;
        was_rd    = !mmode;
      end
      if (ddone) begin
        cap_ndone++;
        if (cap_done_at < 0) begin
          cap_done_at = c;
          cap_err     = derr;
          cap_rd      = drdata;
          cap_rdy     = dready;
        end
      end
      if (sl_en && prev_vld && !mvalid && was_rd) sl_on = 1'b1;
      prev_vld = mvalid;
      svalid = sl_noise;
      srdata = sl_noise;
      if (sl_on && slot <= 10) begin
        if (slot == 4) begin
          svalid = 1'b0;
          srdata = 1'b0;
        end else begin
          idx    = (slot < 4) ? slot : slot - 1;
          svalid = 1'b1;
          srdata = (idx < DW) ? sl_resp[3'(idx)] : 1'b1;
          if (idx == DW - 1) cap_slast = c;
        end
        slot++;
      end
      tick();
    end
    svalid = 1'b0;
    srdata = 1'b0;
  endtask

  task automatic accept(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dvalid = 1'b1;
    dmode  = mode;
    daddr  = a;
    dwdata = d;
    tick();
    dvalid = 1'b0;
  endtask

  int cnt;

  initial begin
    rstn = 1'b0; dvalid = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
    srdata = 1'b0; svalid = 1'b0; sready = 1'b0;
    sl_en = 1'b0; sl_resp = 8'h00; sl_noise = 1'b0;
    tick();
    tick();

    // Reset state
    vec_check("rst_dready", 32'(dready), 32'd1);
    vec_check("rst_mvalid", 32'(mvalid), 32'd0);
    vec_check("rst_mwdata", 32'(mwdata), 32'd0);
    vec_check("rst_mmode",  32'(mmode),  32'd0);
    vec_check("rst_drdata", 32'(drdata), 32'd0);
    vec_check("rst_ddone",  32'(ddone),  32'd0);
    vec_check("rst_derr",   32'(derr),   32'd0);
    rstn = 1'b1;
    tick();

    // Write 0xA5 to 0x3C1 with sready high; stray svalid must not touch drdata.
    sready = 1'b1;
    accept(1'b1, 12'h3C1, 8'hA5);
    sl_noise = 1'b1;
    capture(30);
    sl_noise = 1'b0;
    vec_check("wr1_bits",   cap_bits, 32'h000A_53C1);
    vec_check("wr1_nvld",   32'(cap_nvld), 32'd20);
    vec_check("wr1_first",  32'(cap_first), 32'd1);
    vec_check("wr1_last",   32'(cap_last), 32'd20);
    vec_check("wr1_mmode",  32'(cap_mmode), 32'd1);
    vec_check("wr1_done",   32'(cap_done_at), 32'd22);
    vec_check("wr1_ndone",  32'(cap_ndone), 32'd1);
    vec_check("wr1_derr",   32'(cap_err), 32'd0);
    vec_check("wr1_drdata", 32'(cap_rd), 32'd0);

    // Read 0x00F, slave returns 0x5A.
    sl_en = 1'b1;
    sl_resp = 8'h5A;
    accept(1'b0, 12'h00F, 8'hFF);
    capture(40);
    sl_en = 1'b0;
    vec_check("rd_bits",   cap_bits, 32'h0000_000F);
    vec_check("rd_nvld",   32'(cap_nvld), 32'd12);
    vec_check("rd_last",   32'(cap_last), 32'd12);
    vec_check("rd_mmode",  32'(cap_mmode), 32'd0);
    vec_check("rd_done",   32'(cap_done_at), 32'd24);
    vec_check("rd_lat",    32'(cap_done_at - cap_slast), 32'd3);
    vec_check("rd_drdata", 32'(cap_rd), 32'h5A);
    vec_check("rd_derr",   32'(cap_err), 32'd0);
    vec_check("rd_ndone",  32'(cap_ndone), 32'd1);

    // Read with a silent slave: timeout, drdata keeps 0x5A.
    accept(1'b0, 12'h7E2, 8'h00);
    capture(90);
    vec_check("to_nvld",   32'(cap_nvld), 32'd12);
    vec_check("to_done",   32'(cap_done_at), 32'(AW + TO + 2));
    vec_check("to_derr",   32'(cap_err), 32'd1);
    vec_check("to_drdata", 32'(cap_rd), 32'h5A);
    vec_check("to_dready", 32'(cap_rdy), 32'd1);
    vec_check("to_ndone",  32'(cap_ndone), 32'd1);

    // sready held low for 10 cycles after accept.
    sready = 1'b0;
    accept(1'b1, 12'h0A7, 8'h5C);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mvalid || dready) cnt++;
      tick();
    end
    vec_check("stall_quiet", 32'(cnt), 32'd0);
    sready = 1'b1;
    capture(30);
    vec_check("stall_first", 32'(cap_first), 32'd1);
    vec_check("stall_bits",  cap_bits, 32'h0005_C0A7);
    vec_check("stall_nvld",  32'(cap_nvld), 32'd20);
    vec_check("stall_done",  32'(cap_done_at), 32'd22);

    // dvalid held while busy, then reset in the middle of ADDR.
    accept(1'b1, 12'h123, 8'h77);
    dvalid = 1'b1;
    dmode  = 1'b0;
    daddr  = 12'hFFF;
    capture(6);
    vec_check("busy_bits",   cap_bits, 32'h0000_0003);
    vec_check("busy_nvld",   32'(cap_nvld), 32'd5);
    vec_check("busy_dready", 32'(dready), 32'd0);
    rstn   = 1'b0;
    dvalid = 1'b0;
    tick();
    rstn = 1'b1;
    vec_check("abort_mvalid", 32'(mvalid), 32'd0);
    vec_check("abort_dready", 32'(dready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (ddone || mvalid) cnt++;
      tick();
    end
    vec_check("abort_quiet", 32'(cnt), 32'd0);

    // The next request completes normally.
    accept(1'b1, 12'h800, 8'h3C);
    capture(30);
    vec_check("post_bits", cap_bits, 32'h0003_C800);
    vec_check("post_nvld", 32'(cap_nvld), 32'd20);
    vec_check("post_done", 32'(cap_done_at), 32'd22);
    vec_check("post_derr", 32'(cap_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
